// File: rtl/if_id_queue_if.sv
// if_id_queue_if: IF -> queue -> ID handshake bundle.
//   master : fetch/decode side (drives in_*, out_ready, flush)
//   slave  : queue side (drives in_ready, out_*, count)
//   in_valid/in_ready/in_instr/in_pc : push channel from IF
//   out_valid/out_ready/out_instr/out_pc : pop channel to ID
//   flush : discard all queued entries
//   count : occupancy, 0..DEPTH
interface if_id_queue_if #(
    parameter int DEPTH = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [31:0]              in_instr;
    logic [31:0]              in_pc;
    logic                     out_valid;
    logic                     out_ready;
    logic [31:0]              out_instr;
    logic [31:0]              out_pc;
    logic                     flush;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output in_valid, in_instr, in_pc, out_ready, flush,
        input  in_ready, out_valid, out_instr, out_pc, count
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready, flush,
        output in_ready, out_valid, out_instr, out_pc, count
    );
endinterface

// File: rtl/if_id_queue.sv
// if_id_queue: DEPTH-entry instruction/PC FIFO between fetch and decode.
// Presents NOP with PC 0 when empty; flush drops every entry in one cycle.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (pointers/count only)
//   q     : slave side of if_id_queue_if (push, pop, flush, count)
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module if_id_queue #(
    parameter int          DEPTH = 4,
    parameter logic [31:0] NOP   = 32'hC8000000
) (
    input  logic          clk,
    input  logic          rst_n,
    if_id_queue_if.slave  q
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   cnt;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;

    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);

    // Flush wins over both handshakes; neither side sees its transfer.
    assign push = q.in_valid  & ~full  & ~q.flush;
    assign pop  = q.out_ready & ~empty & ~q.flush;

    // Storage is not reset: only pointers/count define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{instr: q.in_instr, pc: q.in_pc};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (q.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    // Status comes from registered state only; data is a read of mem
    // gated by occupancy, so there is no same-cycle bypass.
    assign q.in_ready  = ~full;
    assign q.out_valid = ~empty;
    assign q.count     = cnt;
    assign q.out_instr = empty ? NOP   : mem[rd_ptr].instr;
    assign q.out_pc    = empty ? '0    : mem[rd_ptr].pc;
endmodule
